// File: rtl/reg_read_stage_pkg.sv
// Shared core constants and types for the operand-read stage.
package reg_read_stage_pkg;

  localparam int REG_LOG    = 5;
  localparam int DATA_WIDTH = 64;
  localparam int TAG_W      = 8;
  localparam int REG_CNT    = 2 ** REG_LOG;

  typedef logic [REG_LOG-1:0]    reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [TAG_W-1:0]      tag_t;

endpackage

// File: rtl/reg_read_stage_if.sv
// Issue (decode -> stage) and operand (stage -> execute) channels.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The sender holds its payload stable while valid is high and ready is low.
// ready never depends combinationally on valid on the same channel.
interface reg_read_stage_if
  import reg_read_stage_pkg::*;
  ;

  logic      in_valid;
  logic      in_ready;
  reg_idx_t  in_rs1;
  reg_idx_t  in_rs2;
  reg_idx_t  in_rd;
  logic      in_rd_en;
  tag_t      in_tag;

  logic      out_valid;
  logic      out_ready;
  reg_data_t out_rs1_data;
  reg_data_t out_rs2_data;
  reg_idx_t  out_rd;
  logic      out_rd_en;
  tag_t      out_tag;

  // Stage side: consumes issue channel, produces operand channel.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en, in_tag, out_ready,
    output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en, out_tag
  );

  // Environment side: decode feeds issue channel, execute drains operands.
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_en, in_tag, out_ready,
    input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en, out_tag
  );

endinterface

// File: rtl/reg_read_stage_operand_read.sv
// One source operand: zero register, same-cycle writeback bypass, array read,
// and a hazard flag when the source still has a pending producer.
module reg_operand_read
  import reg_read_stage_pkg::*;
(
  input  reg_idx_t                  sel,
  input  reg_data_t [REG_CNT-1:0]   regs,
  input  logic                      wb_valid,
  input  reg_idx_t                  wb_sel,
  input  reg_data_t                 wb_data,
  input  logic [REG_CNT-1:0]        busy,
  output reg_data_t                 data,
  output logic                      hazard
);

  logic wb_hit;

  assign wb_hit = wb_valid && (wb_sel == sel);

  // Register 0 reads as zero; a writeback in flight this cycle beats the array.
  always_comb begin
    data = regs[sel];
    if (sel == '0) begin
      data = '0;
    end else if (wb_hit) begin
      data = wb_data;
    end
  end

  // The bypass resolves the hazard in the same cycle the producer writes back.
  assign hazard = (sel != '0) && busy[sel] && !wb_hit;

endmodule

// File: rtl/reg_read_stage.sv
// Operand-read stage: reads two sources with writeback bypass, tracks pending
// destinations in a busy scoreboard, stalls on RAW/WAW, and holds operands in
// a one-deep registered output for execute.
module reg_read_stage
  import reg_read_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  reg_data_t [REG_CNT-1:0] regs,
  input  logic                    wb_valid,
  input  reg_idx_t                wb_sel,
  input  reg_data_t               wb_data,
  input  logic                    flush,
  reg_read_stage_if.slave         bus,
  output logic [REG_CNT-1:0]      busy
);

  reg_data_t          rs1_data;
  reg_data_t          rs2_data;
  logic               rs1_hazard;
  logic               rs2_hazard;
  logic               waw_hazard;
  logic               accept;
  logic               in_ready;
  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] busy_next;

  logic               out_valid_q;
  reg_data_t          out_rs1_q;
  reg_data_t          out_rs2_q;
  reg_idx_t           out_rd_q;
  logic               out_rd_en_q;
  tag_t               out_tag_q;

  reg_operand_read u_rs1 (
    .sel     (bus.in_rs1),
    .regs    (regs),
    .wb_valid(wb_valid),
    .wb_sel  (wb_sel),
    .wb_data (wb_data),
    .busy    (busy_q),
    .data    (rs1_data),
    .hazard  (rs1_hazard)
  );

  reg_operand_read u_rs2 (
    .sel     (bus.in_rs2),
    .regs    (regs),
    .wb_valid(wb_valid),
    .wb_sel  (wb_sel),
    .wb_data (wb_data),
    .busy    (busy_q),
    .data    (rs2_data),
    .hazard  (rs2_hazard)
  );

  // A destination still owned by an older producer must not be re-claimed,
  // unless that producer writes back in this very cycle.
  assign waw_hazard = bus.in_rd_en && (bus.in_rd != '0) && busy_q[bus.in_rd]
                      && !(wb_valid && (wb_sel == bus.in_rd));

  assign in_ready = reset_n && !flush && (!out_valid_q || bus.out_ready)
                    && !rs1_hazard && !rs2_hazard && !waw_hazard;

  assign accept = bus.in_valid && in_ready;

  // Scoreboard next state: writeback clears, a new claim sets and wins a tie.
  always_comb begin
    busy_next = busy_q;
    if (wb_valid && (wb_sel != '0)) begin
      busy_next[wb_sel] = 1'b0;
    end
    if (accept && bus.in_rd_en && (bus.in_rd != '0)) begin
      busy_next[bus.in_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Output register and scoreboard; flush drops the held entry and all claims.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_en_q <= 1'b0;
      out_tag_q   <= '0;
      busy_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      busy_q <= busy_next;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_rs1_q   <= rs1_data;
        out_rs2_q   <= rs2_data;
        out_rd_q    <= bus.in_rd;
        out_rd_en_q <= bus.in_rd_en;
        out_tag_q   <= bus.in_tag;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1_data = out_rs1_q;
  assign bus.out_rs2_data = out_rs2_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_rd_en    = out_rd_en_q;
  assign bus.out_tag      = out_tag_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: reset, plain read, bypass, RAW/WAW
// stalls, backpressure with same-index set/clear, and flush.
module tb_reg_read_stage;
  import reg_read_stage_pkg::*;

  logic                    clk;
  logic                    reset_n;
  reg_data_t [REG_CNT-1:0] regs;
  logic                    wb_valid;
  reg_idx_t                wb_sel;
  reg_data_t               wb_data;
  logic                    flush;
  logic [REG_CNT-1:0]      busy;

  int checks;
  int failures;

  reg_read_stage_if bus ();

  reg_read_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .regs    (regs),
    .wb_valid(wb_valid),
    .wb_sel  (wb_sel),
    .wb_data (wb_data),
    .flush   (flush),
    .bus     (bus.slave),
    .busy    (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check counts and reports here.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd,
                       input logic rd_en, input int tag);
    bus.in_valid = 1'b1;
    bus.in_rs1   = reg_idx_t'(rs1);
    bus.in_rs2   = reg_idx_t'(rs2);
    bus.in_rd    = reg_idx_t'(rd);
    bus.in_rd_en = rd_en;
    bus.in_tag   = tag_t'(tag);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic v, input int sel, input logic [63:0] data);
    wb_valid = v;
    wb_sel   = reg_idx_t'(sel);
    wb_data  = data;
  endtask

  function automatic logic [63:0] bit_of(input int i);
    logic [63:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    regs     = '0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    wb(1'b0, 0, 64'h0);
    bus.out_ready = 1'b1;
    idle();
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_rd = '0;
    bus.in_rd_en = 1'b0;
    bus.in_tag = '0;

    // Reset then idle
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_out_tag", 64'(bus.out_tag), 64'h0);
    check("rst_out_data", bus.out_rs1_data, 64'h0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);

    // Plain read, then r0 reads zero despite array contents
    regs[0] = 64'hDEAD;
    regs[3] = 64'h11;
    regs[4] = 64'h22;
    issue(3, 4, 0, 1'b0, 1);
    tick();
    check("plain_valid", 64'(bus.out_valid), 64'h1);
    check("plain_rs1", bus.out_rs1_data, 64'h11);
    check("plain_rs2", bus.out_rs2_data, 64'h22);
    check("plain_tag", 64'(bus.out_tag), 64'h1);
    issue(0, 3, 0, 1'b0, 2);
    tick();
    check("r0_rs1", bus.out_rs1_data, 64'h0);
    check("r0_rs2", bus.out_rs2_data, 64'h11);
    idle();
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'h0);

    // Same-cycle writeback bypass
    regs[5] = 64'hAA;
    wb(1'b1, 5, 64'hBB);
    issue(5, 4, 0, 1'b0, 3);
    tick();
    wb(1'b0, 0, 64'h0);
    idle();
    check("bypass_rs1", bus.out_rs1_data, 64'hBB);
    check("bypass_rs2", bus.out_rs2_data, 64'h22);

    // RAW stall on rs2 until writeback of r7
    issue(1, 2, 7, 1'b1, 4);
    tick();
    idle();
    check("raw_busy_set", 64'(busy), bit_of(7));
    check("raw_out_rd", 64'(bus.out_rd), 64'h7);
    issue(0, 7, 0, 1'b0, 5);
    #1;
    check("raw_stall_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("raw_stall_valid", 64'(bus.out_valid), 64'h0);
    check("raw_stall_busy", 64'(busy), bit_of(7));
    wb(1'b1, 7, 64'h77);
    #1;
    check("raw_wb_ready", 64'(bus.in_ready), 64'h1);
    tick();
    wb(1'b0, 0, 64'h0);
    idle();
    check("raw_rs2", bus.out_rs2_data, 64'h77);
    check("raw_tag", 64'(bus.out_tag), 64'h5);
    check("raw_busy_clr", 64'(busy), 64'h0);

    // WAW stall on r8; rd=0 with rd_en is not a hazard
    issue(0, 0, 8, 1'b1, 6);
    tick();
    issue(0, 0, 8, 1'b1, 7);
    #1;
    check("waw_ready", 64'(bus.in_ready), 64'h0);
    issue(0, 0, 0, 1'b1, 8);
    #1;
    check("rd0_ready", 64'(bus.in_ready), 64'h1);
    wb(1'b1, 8, 64'h88);
    tick();
    wb(1'b0, 0, 64'h0);
    idle();
    check("rd0_busy", 64'(busy), 64'h0);
    check("rd0_tag", 64'(bus.out_tag), 64'h8);

    // Same-index set and clear: set wins
    issue(3, 4, 9, 1'b1, 9);
    wb(1'b1, 9, 64'h99);
    tick();
    wb(1'b0, 0, 64'h0);
    idle();
    check("setclr_busy", 64'(busy), bit_of(9));

    // Backpressure holds the output and blocks issue
    bus.out_ready = 1'b0;
    issue(4, 0, 2, 1'b1, 10);
    #1;
    check("bp_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("bp_valid", 64'(bus.out_valid), 64'h1);
    check("bp_tag", 64'(bus.out_tag), 64'h9);
    check("bp_rs1", bus.out_rs1_data, 64'h11);
    check("bp_rd", 64'(bus.out_rd), 64'h9);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'h1);
    tick();
    idle();
    check("bp_next_tag", 64'(bus.out_tag), 64'hA);
    check("bp_next_rs1", bus.out_rs1_data, 64'h22);
    check("bp_busy", 64'(busy), bit_of(9) | bit_of(2));

    // Flush with busy={2,9} and a held entry; no accept that cycle
    bus.out_ready = 1'b0;
    flush = 1'b1;
    wb(1'b1, 9, 64'h5);
    issue(0, 0, 3, 1'b1, 11);
    #1;
    check("flush_ready", 64'(bus.in_ready), 64'h0);
    tick();
    flush = 1'b0;
    wb(1'b0, 0, 64'h0);
    idle();
    check("flush_valid", 64'(bus.out_valid), 64'h0);
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_tag_hold", 64'(bus.out_tag), 64'hA);

    // Issue resumes after flush with clean scoreboard
    bus.out_ready = 1'b1;
    issue(9, 2, 0, 1'b0, 12);
    #1;
    check("post_flush_ready", 64'(bus.in_ready), 64'h1);
    tick();
    idle();
    check("post_flush_tag", 64'(bus.out_tag), 64'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Operand-read and scoreboard stage sitting between decode and execute in the 64-bit core. It reads two source registers from the architectural register array and forwards the same-cycle writeback value. It tracks pending destination registers in a busy scoreboard and stalls issue on RAW/WAW hazards. Operands are delivered through a one-deep registered valid/ready output.

## Interface
- REG_LOG, 5, log2 of register count (32 registers)
- DATA_WIDTH, 64, register width in bits
- TAG_W, 8, width of opaque instruction tag carried alongside
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- regs  in  [2**REG_LOG-1:0][DATA_WIDTH-1:0]  architectural register array (pre-write contents this cycle)
- wb_valid  in  1  writeback this cycle
- wb_sel  in  REG_LOG  writeback register index
- wb_data  in  DATA_WIDTH  writeback value
- flush  in  1  discard held output and clear scoreboard
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  REG_LOG  source indices
- in_rd  in  REG_LOG  destination index
- in_rd_en  in  1  instruction writes in_rd
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  operands held for execute
- out_ready  in  1  execute consumes this cycle
- out_rs1_data, out_rs2_data  out  DATA_WIDTH  operand values
- out_rd, out_rd_en, out_tag  out  as inputs  registered copies
- busy  out  2**REG_LOG  scoreboard, bit i = register i has a pending producer

## Operation
- Operand read (per source s): s==0 -> 0; else wb_valid && wb_sel==s -> wb_data; else regs[s].
- Source hazard: s!=0 && busy[s] && !(wb_valid && wb_sel==s).
- WAW hazard: in_rd_en && in_rd!=0 && busy[in_rd] && !(wb_valid && wb_sel==in_rd).
- in_ready = reset_n && !flush && (!out_valid || out_ready) && no source hazard on rs1/rs2 && no WAW hazard.
- Accept (in_valid && in_ready): output register loads operands, rd, rd_en, tag; out_valid<=1.
- out_valid && out_ready && no accept: out_valid<=0, data outputs hold their last value.
- Scoreboard: wb_valid && wb_sel!=0 clears busy[wb_sel]; accept with in_rd_en && in_rd!=0 sets busy[in_rd]; if set and clear hit the same index in one cycle, set wins. busy[0] is always 0.
- in_rd_en with in_rd==0 is accepted; it neither sets busy nor stalls.
- flush: out_valid<=0, busy<=0, no accept that cycle; a simultaneous wb is ignored by the scoreboard.
- Captured operands are not updated by later writebacks (they cannot occur: the source was not busy at capture).

## Timing
- Reset (reset_n low at a clk edge): out_valid=0, busy=0, out_* data/rd/rd_en/tag=0; in_ready=0 while reset_n low.
- Latency 1 cycle, in accept to out_valid. Throughput 1/cycle when out_ready is held high.
- in_ready is combinational from wb_*, flush, out_ready, and the in_* indices; no combinational path from in_valid to in_ready.
- Bypass uses the same-cycle wb; a wb arriving one cycle later is seen via regs.
- Reset or flush mid-stall drops the held instruction; the upstream re-presents it.

## Structure
- Shared core package: REG_LOG, DATA_WIDTH, TAG_W constants; reg_idx_t (logic [REG_LOG-1:0]); reg_data_t (logic [DATA_WIDTH-1:0]).
- Sub-module reg_operand_read: combinational zero/bypass/array mux plus hazard bit for one source. Instantiated twice.
- Top holds the output register, the scoreboard, and the ready logic.

## Test plan
- Reset then idle: after reset_n low for 2 cycles -> out_valid=0, busy=0, in_ready=0 during reset and 1 after.
- Plain read: regs[3]=0x11, regs[4]=0x22, issue rs1=3, rs2=4 -> next cycle out_valid=1, data 0x11/0x22; rs1=0 -> 0 regardless of regs[0].
- Bypass: regs[5]=0xAA, same cycle wb_valid, wb_sel=5, wb_data=0xBB, issue rs1=5 -> out_rs1_data=0xBB.
- RAW stall: issue rd=7 rd_en=1 -> busy[7]=1; next instruction with rs2=7 sees in_ready=0 until a wb to 7 with 0x77; on that cycle it is accepted with out_rs2_data=0x77 and busy[7]=0.
- Backpressure and same-index set/clear: out_ready=0 holds out_* stable and in_ready=0. Accepting rd=9 while wb_sel=9 leaves busy[9]=1.
- Flush: with busy={2,9} and out_valid=1, pulse flush -> next cycle out_valid=0, busy=0, and no instruction accepted during the flush cycle.
